// File: rtl/mem_line_responder_pkg.sv
// Shared widths and encodings for the main-memory line responder.
// Package is named mem_pkg so the cache side can reuse the same line/address widths.
package mem_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;
endpackage

// File: rtl/mem_line_responder_if.sv
// Memory-side line port between the L2 cache (master) and the responder (slave).
interface mem_line_responder_if;
  import mem_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_line_array.sv
// DEPTH x LINE_W line storage: one synchronous write port, one combinational read port,
// whole array cleared by reset.
module mem_line_array
  import mem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic [LINE_W-1:0] o_rdata
);
  localparam int DEPTH = 1 << IDX_W;

  logic [LINE_W-1:0] r_lines [DEPTH];

  // NOTE: this storage must be cleared by reset, so it is built from flops rather than
  // a RAM macro; the reset loop is what rules out block-RAM inference here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lines[i] <= '0;
      end
    end else if (i_we) begin
      r_lines[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_lines[i_ridx];
endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency main-memory model for the L2 memory port: one line transaction at a time,
// one-cycle mem_ready pulse, read/write statistics and a sticky protocol-error flag.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_line_responder_if.slave bus,
  output logic [CNT_W-1:0] read_cnt,
  output logic [CNT_W-1:0] write_cnt,
  output logic             proto_err
);
  localparam bit       DIRECT   = (LATENCY == 1);
  localparam logic [7:0] CNT_LOAD = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t            r_state, w_next_state;
  logic [7:0]        r_cnt, w_next_cnt;
  op_t               r_op, w_op_eff;
  logic [IDX_W-1:0]  r_idx, w_idx_eff;
  logic [LINE_W-1:0] r_wdata;
  logic              r_ready;
  logic [LINE_W-1:0] r_rdata, w_rdata_d, w_arr_rdata;
  logic [CNT_W-1:0]  r_read_cnt, r_write_cnt;
  logic              r_proto_err;

  logic w_req_rd, w_req_wr, w_conflict, w_start, w_we;
  logic w_unused_addr;

  assign w_req_rd      = bus.mem_read & ~bus.mem_write;
  assign w_req_wr      = bus.mem_write & ~bus.mem_read;
  assign w_conflict    = bus.mem_read & bus.mem_write;
  assign w_unused_addr = ^bus.mem_addr[ADDR_W-1:IDX_W];

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_start      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_rd || w_req_wr) begin
          w_start = 1'b1;
          if (DIRECT) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
            w_next_cnt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 8'd0) w_next_state = S_RESP;
        else               w_next_cnt   = r_cnt - 8'd1;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // On the starting edge the request has not been latched yet, so use the live inputs.
  always_comb begin
    w_op_eff  = r_op;
    w_idx_eff = r_idx;
    if (w_start) begin
      w_op_eff  = w_req_wr ? OP_WRITE : OP_READ;
      w_idx_eff = bus.mem_addr[IDX_W-1:0];
    end
    w_rdata_d = '0;
    if (w_next_state == S_RESP && w_op_eff == OP_READ) w_rdata_d = w_arr_rdata;
  end

  assign w_we = (r_state == S_RESP) && (r_op == OP_WRITE);

  mem_line_array #(.IDX_W(IDX_W)) u_array (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wdata (r_wdata),
    .i_ridx  (w_idx_eff),
    .o_rdata (w_arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_READ;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ready <= (w_next_state == S_RESP);
      r_rdata <= w_rdata_d;
      if (w_start) begin
        r_op    <= w_op_eff;
        r_idx   <= w_idx_eff;
        r_wdata <= bus.mem_wdata;
      end
      if (r_state == S_RESP) begin
        if (r_op == OP_READ) r_read_cnt  <= r_read_cnt + 1'b1;
        else                 r_write_cnt <= r_write_cnt + 1'b1;
      end
      if (r_state == S_IDLE && w_conflict) r_proto_err <= 1'b1;
    end
  end

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign read_cnt      = r_read_cnt;
  assign write_cnt     = r_write_cnt;
  assign proto_err     = r_proto_err;
endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: directed plan scenarios plus randomized traffic
// against an array-based line model; a second instance covers LATENCY=1.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int LAT = 8;

  typedef struct {
    bit           is_read;
    logic [127:0] data;
    int unsigned  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_line_responder_if bus ();
  mem_line_responder_if bus1 ();
  logic [31:0] rd_cnt, wr_cnt, rd_cnt1, wr_cnt1;
  logic        perr, perr1;

  mem_line_responder #(.LATENCY(LAT), .IDX_W(8)) dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .read_cnt(rd_cnt), .write_cnt(wr_cnt), .proto_err(perr)
  );

  mem_line_responder #(.LATENCY(1), .IDX_W(8)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1),
    .read_cnt(rd_cnt1), .write_cnt(wr_cnt1), .proto_err(perr1)
  );

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [127:0] model [256];
  int exp_rd = 0;
  int exp_wr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mem_ready pops one expectation; outside mem_ready rdata must be zero.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_ready) begin
        if (sb.size() == 0) begin
          check("spurious_ready", 128'd1, 128'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ready_cycle", 128'(cyc), 128'(mon_e.cyc));
          check("rdata", bus.mem_rdata, mon_e.data);
        end
      end else begin
        check("rdata_idle", bus.mem_rdata, 128'd0);
      end
    end
  end

  task automatic drive_idle();
    bus.mem_read = 1'b0;  bus.mem_write = 1'b0;
    bus.mem_addr = '0;    bus.mem_wdata = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
    bus1.mem_addr = '0;   bus1.mem_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    sb.delete();
    for (int i = 0; i < 256; i++) model[i] = '0;
    exp_rd = 0;
    exp_wr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after mem_ready with the request dropped.
  task automatic do_txn(input bit is_read, input logic [27:0] addr, input logic [127:0] wdata,
                        input bit scramble);
    exp_t e;
    int   n;
    bit   done;
    bus.mem_read  = is_read;
    bus.mem_write = !is_read;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    e.is_read = is_read;
    e.cyc     = cyc + LAT;
    e.data    = is_read ? model[addr[7:0]] : 128'd0;
    if (is_read) exp_rd++;
    else begin
      exp_wr++;
      model[addr[7:0]] = wdata;
    end
    sb.push_back(e);
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.mem_ready) done = 1'b1;
      else if (n > 300) begin
        check("ready_timeout", 128'd0, 128'd1);
        sb.delete();
        done = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
        if (scramble) begin
          bus.mem_addr  = 28'($urandom());
          bus.mem_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          if ($urandom_range(0, 3) == 0) begin
            bus.mem_read = 1'b0; bus.mem_write = 1'b0;
          end else if (bus.mem_read || bus.mem_write) begin
            bus.mem_read  = !bus.mem_read;
            bus.mem_write = !bus.mem_write;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int unsigned c0;
  int unsigned ready_cycles[$];
  logic [27:0]  r_addr;
  logic [127:0] r_data;
  bit           r_op;

  initial begin
    do_reset();
    idle_cycles(1);
    check("rst_ready", 128'(bus.mem_ready), 128'd0);
    check("rst_rdata", bus.mem_rdata, 128'd0);
    check("rst_rd_cnt", 128'(rd_cnt), 128'd0);
    check("rst_wr_cnt", 128'(wr_cnt), 128'd0);
    check("rst_perr", 128'(perr), 128'd0);

    // Single read of an untouched line.
    do_txn(1'b1, 28'h0000005, '0, 1'b0);
    check("single_rd_cnt", 128'(rd_cnt), 128'd1);

    // Write then immediate read of the same line, then an aliased pair.
    do_txn(1'b0, 28'h0000012, 128'hDEADBEEF_00000001_CAFEF00D_12345678, 1'b0);
    do_txn(1'b1, 28'h0000012, '0, 1'b0);
    check("wr_rd_wr_cnt", 128'(wr_cnt), 128'd1);
    check("wr_rd_rd_cnt", 128'(rd_cnt), 128'd2);
    do_txn(1'b0, 28'h0000112, 128'hA5, 1'b0);
    do_txn(1'b1, 28'h0000012, '0, 1'b0);
    idle_cycles(2);

    // Simultaneous read and write: no transaction, sticky error.
    do_reset();
    bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.mem_addr = 28'h20;
    idle_cycles(3);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    idle_cycles(LAT + 3);
    check("perr_set", 128'(perr), 128'd1);
    check("perr_rd_cnt", 128'(rd_cnt), 128'd0);
    check("perr_wr_cnt", 128'(wr_cnt), 128'd0);
    do_txn(1'b1, 28'h0000020, '0, 1'b0);
    check("perr_sticky", 128'(perr), 128'd1);

    // Reset during a write's latency wait: nothing committed, no ready.
    do_reset();
    bus.mem_write = 1'b1; bus.mem_addr = 28'h33; bus.mem_wdata = 128'h1234_5678_9ABC;
    idle_cycles(4);
    rst_n = 1'b0;
    drive_idle();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(LAT + 2);
    check("abort_wr_cnt", 128'(wr_cnt), 128'd0);
    check("abort_rd_cnt", 128'(rd_cnt), 128'd0);
    do_txn(1'b1, 28'h0000033, '0, 1'b0);
    check("abort_wr_cnt2", 128'(wr_cnt), 128'd0);

    // Random traffic with input churn during the wait.
    for (int t = 0; t < 80; t++) begin
      r_op   = 1'($urandom_range(0, 1));
      r_addr = 28'($urandom());
      if ($urandom_range(0, 3) != 0) r_addr[7:0] = 8'($urandom_range(0, 15));
      r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_txn(r_op, r_addr, r_data, 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(LAT + 2);
    check("final_rd_cnt", 128'(rd_cnt), 128'(exp_rd));
    check("final_wr_cnt", 128'(wr_cnt), 128'(exp_wr));
    check("sb_empty", 128'(sb.size()), 128'd0);

    // LATENCY=1: held read gives ready in cycles 1, 3, 5.
    do_reset();
    bus1.mem_read = 1'b1; bus1.mem_addr = 28'h7;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus1.mem_ready) begin
        ready_cycles.push_back(cyc - c0);
        check("lat1_rdata", bus1.mem_rdata, 128'd0);
      end
      @(posedge clk);
      #1;
    end
    bus1.mem_read = 1'b0;
    check("lat1_count", 128'(ready_cycles.size()), 128'd3);
    if (ready_cycles.size() >= 2) begin
      check("lat1_first", 128'(ready_cycles[0]), 128'd1);
      check("lat1_second", 128'(ready_cycles[1]), 128'd3);
    end else begin
      check("lat1_pulses", 128'(ready_cycles.size()), 128'd2);
    end
    idle_cycles(2);
    check("lat1_rd_cnt", 128'(rd_cnt1), 128'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
